// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch front end.
//   ADDR_SIZE  : PC / memory address width
//   INSTR_SIZE : instruction word width
//   BOOT_ADDR  : PC value after reset
//   NOP_INSTR  : word presented to decode when nothing is buffered (addi x0,x0,0)
package fetch_stage_pkg;

    localparam int          ADDR_SIZE  = 32;
    localparam int          INSTR_SIZE = 32;
    localparam logic [31:0] BOOT_ADDR  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO with a combinationally visible head entry.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   push, push_data       write one entry (ignored when full unless popping too)
//   pop                   remove the head entry (ignored when empty)
//   flush                 discard all entries; wins over push and pop
//   head_data             oldest entry (stale data when empty)
//   full, empty, count    occupancy status
module fetch_fifo #(
    parameter int Width = 64,
    parameter int Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [Width-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int                PtrW     = $clog2(Depth);
    localparam logic [PtrW-1:0]   PtrOne   = PtrW'(1);
    localparam logic [PtrW:0]     CntOne   = (PtrW+1)'(1);
    localparam logic [PtrW:0]     DepthCnt = (PtrW+1)'(Depth);

    logic [PtrW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PtrW:0]    count_reg, count_next;
    logic [Width-1:0] entries [Depth];
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DepthCnt);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign do_push = push && (!full || do_pop);

    assign head_data = entries[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + PtrOne;
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PtrOne;
            if (do_push && !do_pop)      count_next = count_reg + CntOne;
            else if (!do_push && do_pop) count_next = count_reg - CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One register per slot; only the slot under the write pointer loads.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        logic [Width-1:0] entry_reg;
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                entry_reg <= '0;
            end else if (do_push && !flush && (wr_ptr_reg == PtrW'(gi))) begin
                entry_reg <= push_data;
            end
        end
        assign entries[gi] = entry_reg;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order requests over a
// req/gnt + rvalid memory interface, buffers returned words with their PC and
// presents them to decode with a valid/stall handshake. Redirects flush the
// buffer and cause responses still in flight to be discarded.
// Ports:
//   clk_i, rst_i                 clock (rising edge), asynchronous active-low reset
//   imem_req_o, imem_addr_o      fetch request and word-aligned address
//   imem_gnt_i                   request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  in-order response
//   redirect_i, redirect_pc_i    branch/jump taken, new PC (low 2 bits ignored)
//   stall_i                      decode cannot accept this cycle
//   if_valid_o, if_pc_o, if_instr_o  instruction presented to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  AddrSize  = ADDR_SIZE,
    parameter int                  InstrSize = INSTR_SIZE,
    parameter logic [AddrSize-1:0] BootAddr  = AddrSize'(BOOT_ADDR),
    parameter int                  Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [AddrSize-1:0]  imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [InstrSize-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [AddrSize-1:0]  redirect_pc_i,
    input  logic                 stall_i,
    output logic                 if_valid_o,
    output logic [AddrSize-1:0]  if_pc_o,
    output logic [InstrSize-1:0] if_instr_o
);

    localparam int                 CntW     = cnt_width(Depth);
    localparam logic [CntW:0]      DepthCnt = (CntW+1)'(Depth);
    localparam logic [CntW-1:0]    CntOne   = CntW'(1);
    localparam logic [InstrSize-1:0] NopWord = InstrSize'(NOP_INSTR);

    logic [AddrSize-1:0] pc_reg, pc_next;
    logic [CntW-1:0]     outstanding_reg, outstanding_next;
    logic [CntW-1:0]     drop_reg, drop_next;
    logic [CntW:0]       credit_used;
    logic                grant, rsp_accept, rsp_keep;

    logic [AddrSize-1:0]           pcq_head;
    logic                          pcq_full, pcq_empty;
    logic [CntW-1:0]               pcq_count;
    logic [AddrSize+InstrSize-1:0] buf_head;
    logic                          buf_full, buf_empty;
    logic [CntW-1:0]               buf_count;
    logic                          buf_pop;
    logic                          unused_ok;

    // Every in-flight request already owns a buffer slot, so the response
    // buffer can never overflow. Requests are held off while in reset.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, buf_count};
    assign imem_req_o  = rst_i && !redirect_i && (credit_used < DepthCnt);
    assign imem_addr_o = pc_reg;
    assign grant       = imem_req_o && imem_gnt_i;

    // Responses with nothing outstanding are leftovers from before a reset.
    assign rsp_accept = imem_rvalid_i && (outstanding_reg != '0);
    assign rsp_keep   = rsp_accept && (drop_reg == '0);

    // PCs of requests granted but not yet answered, in issue order.
    fetch_fifo #(.Width(AddrSize), .Depth(Depth)) u_pc_queue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (grant),
        .push_data (pc_reg),
        .pop       (rsp_accept),
        .flush     (1'b0),
        .head_data (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    assign buf_pop = if_valid_o && !stall_i;

    fetch_fifo #(.Width(AddrSize + InstrSize), .Depth(Depth)) u_resp_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (rsp_keep),
        .push_data ({pcq_head, imem_rdata_i}),
        .pop       (buf_pop),
        .flush     (redirect_i),
        .head_data (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        if (redirect_i) begin
            // No grant is possible this cycle; everything still in flight
            // after this edge belongs to the old path and must be dropped.
            pc_next          = {redirect_pc_i[AddrSize-1:2], 2'b00};
            outstanding_next = outstanding_reg - CntW'(rsp_accept);
            drop_next        = outstanding_reg - CntW'(rsp_accept);
        end else begin
            if (grant) pc_next = pc_reg + AddrSize'(4);
            outstanding_next = outstanding_reg + CntW'(grant) - CntW'(rsp_accept);
            if (rsp_accept && !rsp_keep) drop_next = drop_reg - CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_reg          <= BootAddr;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    assign if_valid_o = !buf_empty;
    assign if_pc_o    = buf_empty ? '0 : buf_head[AddrSize+InstrSize-1:InstrSize];
    assign if_instr_o = buf_empty ? NopWord : buf_head[InstrSize-1:0];

    // Status outputs that the credit scheme makes redundant.
    assign unused_ok = &{1'b0, pcq_full, pcq_empty, pcq_count, buf_full,
                         redirect_pc_i[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based reference model of the
// fetch front end plus an in-order memory with random latency.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(
        .AddrSize (32),
        .InstrSize(32),
        .BootAddr (BOOT),
        .Depth    (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o)
    );

    typedef struct { logic [31:0] addr; bit dropped; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } word_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;

    // Reference model: requests in flight (tagged when made stale by a
    // redirect) and words waiting for decode.
    flight_t     m_flight[$];
    word_t       m_buf[$];
    logic [31:0] m_pc;
    // Memory environment.
    memreq_t     mem_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int gnt_pct = 100, stall_pct = 0, rvalid_pct = 100, redir_pct = 0;
    int lat_lo = 1, lat_hi = 1;
    bit          force_redirect = 0;
    logic [31:0] force_rpc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, imem_req_o}, 32'h0);
        check({tag, "_addr"},  imem_addr_o, BOOT);
        check({tag, "_valid"}, {31'b0, if_valid_o}, 32'h0);
        check({tag, "_pc"},    if_pc_o, 32'h0);
        check({tag, "_instr"}, if_instr_o, NOP);
    endtask

    task automatic model_reset();
        m_pc = BOOT;
        m_flight.delete();
        m_buf.delete();
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic do_cycle();
        logic        gnt, stall, redir, rv, exp_req, pop_ok;
        logic [31:0] rpc, rdata;
        flight_t     f;
        word_t       w;
        memreq_t     mr;

        gnt   = ($urandom_range(99) < gnt_pct);
        stall = ($urandom_range(99) < stall_pct);
        redir = force_redirect || ($urandom_range(99) < redir_pct);
        rpc   = force_redirect ? force_rpc : $urandom();
        rv    = 1'b0;
        rdata = $urandom();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < rvalid_pct) begin
            rv    = 1'b1;
            rdata = mem_word(mem_q[0].addr);
        end
        imem_gnt_i    = gnt;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdata;
        #1;

        exp_req = !redir && ((m_flight.size() + m_buf.size()) < DEPTH);
        check("req",   {31'b0, imem_req_o}, {31'b0, exp_req});
        check("addr",  imem_addr_o, m_pc);
        check("valid", {31'b0, if_valid_o}, {31'b0, m_buf.size() > 0});
        check("if_pc", if_pc_o, (m_buf.size() > 0) ? m_buf[0].pc : 32'h0);
        check("if_instr", if_instr_o, (m_buf.size() > 0) ? m_buf[0].instr : NOP);

        // Memory follows what the interface actually did.
        if (imem_req_o && gnt) begin
            mr.addr = imem_addr_o;
            mr.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            mem_q.push_back(mr);
        end
        if (rv) mr = mem_q.pop_front();

        // Model update for this edge.
        pop_ok = (m_buf.size() > 0) && !stall && !redir;
        if (pop_ok) begin
            w = m_buf.pop_front();
            $display("IF pc=%h instr=%h", w.pc, w.instr);
        end
        if (rv && m_flight.size() > 0) begin
            f = m_flight.pop_front();
            if (!f.dropped) begin
                w.pc    = f.addr;
                w.instr = mem_word(f.addr);
                m_buf.push_back(w);
            end
        end
        if (redir) begin
            m_buf.delete();
            foreach (m_flight[i]) m_flight[i].dropped = 1'b1;
            m_pc = rpc & ~32'h3;
        end else if (exp_req && gnt) begin
            f.addr    = m_pc;
            f.dropped = 1'b0;
            m_flight.push_back(f);
            m_pc = m_pc + 32'd4;
        end

        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        // Power-on reset.
        #1;
        check_reset_outputs("por");
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Streaming: always granted, single-cycle memory, no stall.
        run(12);

        // Decode stalled: buffer fills to Depth, requests stop, head holds.
        stall_pct = 100;
        run(5);
        check("stall_full_valid", {31'b0, if_valid_o}, 32'h1);
        stall_pct = 0;
        run(6);

        // Grant withheld: address must hold.
        gnt_pct = 0;
        run(3);
        gnt_pct = 100;
        run(4);

        // Redirect with two requests in flight.
        lat_lo = 3;
        lat_hi = 3;
        begin
            int k;
            for (k = 0; k < 20 && m_flight.size() != DEPTH; k++) do_cycle();
            check("two_in_flight", m_flight.size(), DEPTH);
        end
        force_redirect = 1'b1;
        force_rpc      = 32'h0000_0103;
        do_cycle();
        force_redirect = 1'b0;
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        begin
            int k;
            for (k = 0; k < 20 && !if_valid_o; k++) do_cycle();
            check("redir_first_valid", {31'b0, if_valid_o}, 32'h1);
            check("redir_first_pc", if_pc_o, 32'h0000_0100);
        end

        // PC wrap past the top of the address space.
        lat_lo = 1;
        lat_hi = 1;
        force_redirect = 1'b1;
        force_rpc      = 32'hFFFF_FFF8;
        do_cycle();
        force_redirect = 1'b0;
        run(10);

        // Asynchronous reset mid-stream with responses still pending.
        lat_lo = 2;
        lat_hi = 3;
        run(5);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        rst_i = 1'b1;
        gnt_pct    = 0;
        rvalid_pct = 100;
        run(4);
        mem_q.delete();
        gnt_pct = 100;
        lat_lo  = 1;
        lat_hi  = 1;
        run(8);

        // Random traffic.
        lat_lo     = 1;
        lat_hi     = 4;
        gnt_pct    = 70;
        stall_pct  = 30;
        rvalid_pct = 80;
        redir_pct  = 5;
        run(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
